// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer in front of the 32-bit combinational ALU (IDLE -> ISSUE -> WB).
// Optional macro ALU_ISSUE_SLT_EN enables SLT/SLTU/SLTI/SLTIU decode and result shaping.
module alu_issue_ctrl #(
  parameter int XLEN       = 32,
  parameter bit ILLEGAL_WB = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_s,
  input  logic [XLEN-1:0] alu_e,
  input  logic            alu_cout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            out_illegal
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  state_t          state;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            dec_illegal;
  logic [3:0]      dec_s;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [XLEN-1:0] result;

`ifdef ALU_ISSUE_SLT_EN
  typedef enum logic [1:0] {SLT_NONE, SLT_SIGNED, SLT_UNSIGNED} slt_t;
  slt_t dec_slt;
  slt_t slt_q;
  logic unused_bits;
  assign unused_bits = ^in_instr[19:15];
`else
  logic unused_bits;
  assign unused_bits = ^{in_instr[19:15], alu_cout};
`endif

  assign opcode    = in_instr[6:0];
  assign funct3    = in_instr[14:12];
  assign funct7    = in_instr[31:25];
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == WB);

  always_comb begin
    dec_illegal = 1'b1;
    dec_s       = 4'b0000;
    dec_a       = in_rs1_data;
    dec_b       = '0;
`ifdef ALU_ISSUE_SLT_EN
    dec_slt     = SLT_NONE;
`endif
    case (opcode)
      OP_R: begin
        dec_b       = in_rs2_data;
        dec_s       = {in_instr[30], funct3};
        dec_illegal = !((funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OP_I: begin
        if (funct3 == 3'b001) begin
          dec_b       = {{(XLEN-5){1'b0}}, in_instr[24:20]};
          dec_s       = 4'b0001;
          dec_illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec_b       = {{(XLEN-5){1'b0}}, in_instr[24:20]};
          dec_s       = {in_instr[30], 3'b101};
          dec_illegal = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
        end else begin
          dec_b       = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
          dec_s       = {1'b0, funct3};
          dec_illegal = 1'b0;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    // Set-less-than is computed as a subtract; the comparison is formed at capture time.
    if (funct3[2:1] == 2'b01) begin
`ifdef ALU_ISSUE_SLT_EN
      dec_s   = 4'b1000;
      dec_slt = funct3[0] ? SLT_UNSIGNED : SLT_SIGNED;
`else
      dec_illegal = 1'b1;
`endif
    end
    if (dec_illegal) begin
      dec_s = 4'b0000;
      dec_a = '0;
      dec_b = '0;
`ifdef ALU_ISSUE_SLT_EN
      dec_slt = SLT_NONE;
`endif
    end
  end

  always_comb begin
    result = alu_e;
`ifdef ALU_ISSUE_SLT_EN
    case (slt_q)
      SLT_UNSIGNED: result = {{(XLEN-1){1'b0}}, alu_cout};
      SLT_SIGNED:   result = {{(XLEN-1){1'b0}},
                              (alu_a[XLEN-1] ^ alu_b[XLEN-1]) ? alu_a[XLEN-1] : alu_e[XLEN-1]};
      default:      result = alu_e;
    endcase
`endif
  end

  // out_rd is zero for both rd=x0 and illegal instructions, so it doubles as the data-kill flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_s       <= 4'b0000;
      out_rd      <= 5'd0;
      out_data    <= '0;
      out_illegal <= 1'b0;
`ifdef ALU_ISSUE_SLT_EN
      slt_q       <= SLT_NONE;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_a       <= dec_a;
            alu_b       <= dec_b;
            alu_s       <= dec_s;
            out_rd      <= dec_illegal ? 5'd0 : in_instr[11:7];
            out_illegal <= dec_illegal;
`ifdef ALU_ISSUE_SLT_EN
            slt_q       <= dec_slt;
`endif
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          out_data <= (out_rd == 5'd0) ? '0 : result;
          state    <= (out_illegal && !ILLEGAL_WB) ? IDLE : WB;
        end
        WB: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl; two instances cover ILLEGAL_WB=1 and ILLEGAL_WB=0.
// A behavioural ALU model closes the loop on alu_a/alu_b/alu_s.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_ready;

  logic        in_ready, out_valid, out_illegal, alu_cout;
  logic [31:0] alu_a, alu_b, alu_e, out_data;
  logic [3:0]  alu_s;
  logic [4:0]  out_rd;

  logic        in_ready0, out_valid0, out_illegal0, alu_cout0;
  logic [31:0] alu_a0, alu_b0, alu_e0, out_data0;
  logic [3:0]  alu_s0;
  logic [4:0]  out_rd0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
    logic signed [31:0] sa;
    logic [31:0]        sra;
    sa  = a;
    sra = sa >>> b[4:0];
    case (s)
      4'b0000: return {1'b0, a} + {1'b0, b};
      4'b1000: return {1'b0, a} - {1'b0, b};
      4'b0111: return {1'b0, a & b};
      4'b0110: return {1'b0, a | b};
      4'b0100: return {1'b0, a ^ b};
      4'b0001: return {1'b0, a << b[4:0]};
      4'b0101: return {1'b0, a >> b[4:0]};
      4'b1101: return {1'b0, sra};
      default: return 33'd0;
    endcase
  endfunction

  assign {alu_cout,  alu_e}  = alu_model(alu_a,  alu_b,  alu_s);
  assign {alu_cout0, alu_e0} = alu_model(alu_a0, alu_b0, alu_s0);

  alu_issue_ctrl #(.XLEN(32), .ILLEGAL_WB(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_e(alu_e), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data), .out_illegal(out_illegal)
  );

  alu_issue_ctrl #(.XLEN(32), .ILLEGAL_WB(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_s(alu_s0), .alu_e(alu_e0), .alu_cout(alu_cout0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_rd(out_rd0),
    .out_data(out_data0), .out_illegal(out_illegal0)
  );

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for in_ready, offers one instruction, and returns during the ISSUE cycle
  // with the input bus scrambled so operand capture at accept is exercised.
  task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] rs1,
                                input logic [31:0] rs2);
    int n = 0;
    while (!in_ready && n < 10) begin
      step();
      n++;
    end
    check_output("accept_ready", {31'd0, in_ready}, 32'd1);
    in_instr    = instr;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
    in_instr    = 32'h0000_0033;
    in_rs1_data = 32'hDEAD_BEEF;
    in_rs2_data = 32'h1234_5678;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_instr    = 32'd0;
    in_rs1_data = 32'd0;
    in_rs2_data = 32'd0;
    out_ready   = 1'b1;
    step();
    step();

    check_output("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_out_data",  out_data,           32'd0);
    check_output("rst_alu_s",     {28'd0, alu_s},     32'd0);
    rst_n = 1'b1;
    #1;
    check_output("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD x5,x1,x2 : 0xFFFFFFFF + 1 wraps to 0
    apply_stimulus(r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd5), 32'hFFFF_FFFF, 32'd1);
    check_output("add_issue_s",     {28'd0, alu_s},     32'h0);
    check_output("add_issue_a",     alu_a,              32'hFFFF_FFFF);
    check_output("add_issue_b",     alu_b,              32'd1);
    check_output("add_issue_ready", {31'd0, in_ready},  32'd0);
    check_output("add_issue_valid", {31'd0, out_valid}, 32'd0);
    step();
    check_output("add_wb_valid", {31'd0, out_valid}, 32'd1);
    check_output("add_wb_ready", {31'd0, in_ready},  32'd0);
    check_output("add_wb_rd",    {27'd0, out_rd},    32'd5);
    check_output("add_wb_data",  out_data,           32'h0);
    check_output("add_wb_ill",   {31'd0, out_illegal}, 32'd0);
    step();
    check_output("add_idle_valid", {31'd0, out_valid}, 32'd0);
    check_output("add_idle_ready", {31'd0, in_ready},  32'd1);

    // SRAI x3,x4,4
    apply_stimulus(i_type({7'b0100000, 5'd4}, 5'd4, 3'b101, 5'd3), 32'h8000_0000, 32'd0);
    check_output("srai_s", {28'd0, alu_s}, 32'hD);
    check_output("srai_b", alu_b,          32'd4);
    step();
    check_output("srai_data", out_data,        32'hF800_0000);
    check_output("srai_rd",   {27'd0, out_rd}, 32'd3);
    step();

    // SUB x3,x4,x6 : 5 - 7
    apply_stimulus(r_type(7'b0100000, 5'd6, 5'd4, 3'b000, 5'd3), 32'd5, 32'd7);
    check_output("sub_s", {28'd0, alu_s}, 32'h8);
    step();
    check_output("sub_data", out_data, 32'hFFFF_FFFE);
    step();

    // XORI x9,x1,0x0F0 and SLLI x9,x1,8 (zero-extended shamt)
    apply_stimulus(i_type(12'h0F0, 5'd1, 3'b100, 5'd9), 32'h0000_FFFF, 32'd0);
    check_output("xori_s", {28'd0, alu_s}, 32'h4);
    step();
    check_output("xori_data", out_data, 32'h0000_FF0F);
    step();
    apply_stimulus(i_type(12'h008, 5'd1, 3'b001, 5'd9), 32'h0000_00AB, 32'd0);
    step();
    check_output("slli_data", out_data, 32'h0000_AB00);
    step();

    // ADDI x7,x0,-1 with writeback held off for five cycles
    out_ready = 1'b0;
    apply_stimulus(i_type(12'hFFF, 5'd0, 3'b000, 5'd7), 32'd0, 32'd0);
    check_output("addi_b_sext", alu_b, 32'hFFFF_FFFF);
    step();
    for (int i = 0; i < 5; i++) begin
      check_output("bp_valid", {31'd0, out_valid}, 32'd1);
      check_output("bp_data",  out_data,           32'hFFFF_FFFF);
      check_output("bp_rd",    {27'd0, out_rd},    32'd7);
      check_output("bp_ready", {31'd0, in_ready},  32'd0);
      step();
    end
    check_output("bp_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    check_output("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check_output("bp_release_ready", {31'd0, in_ready},  32'd1);

    // Load opcode: illegal on both instances
    apply_stimulus(32'h0040_A283, 32'h0000_1111, 32'h0000_2222);
    check_output("ld_issue_s", {28'd0, alu_s}, 32'h0);
    check_output("ld_issue_a", alu_a,          32'h0);
    check_output("ld_issue_b", alu_b,          32'h0);
    step();
    check_output("ld_wb_valid",  {31'd0, out_valid},   32'd1);
    check_output("ld_wb_ill",    {31'd0, out_illegal}, 32'd1);
    check_output("ld_wb_data",   out_data,             32'h0);
    check_output("ld_wb_rd",     {27'd0, out_rd},      32'd0);
    check_output("ld0_no_valid", {31'd0, out_valid0},  32'd0);
    check_output("ld0_ready",    {31'd0, in_ready0},   32'd1);
    step();
    check_output("ld0_still_no_valid", {31'd0, out_valid0}, 32'd0);

    // OR with funct7=0100000 is not a legal R-type encoding
    apply_stimulus(r_type(7'b0100000, 5'd2, 5'd1, 3'b110, 5'd8), 32'h1, 32'h2);
    step();
    check_output("badf7_ill", {31'd0, out_illegal}, 32'd1);
    check_output("badf7_rd",  {27'd0, out_rd},      32'd0);
    step();

    // ADD x0,x1,x2 : destination x0 forces zero data
    apply_stimulus(r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0), 32'd3, 32'd4);
    step();
    check_output("rd0_data", out_data,             32'h0);
    check_output("rd0_rd",   {27'd0, out_rd},      32'd0);
    check_output("rd0_ill",  {31'd0, out_illegal}, 32'd0);
    step();

    // SLT x4,x1,x2 with -1 < 1
    apply_stimulus(r_type(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd4), 32'hFFFF_FFFF, 32'd1);
`ifdef ALU_ISSUE_SLT_EN
    check_output("slt_s", {28'd0, alu_s}, 32'h8);
    step();
    check_output("slt_data", out_data,             32'd1);
    check_output("slt_ill",  {31'd0, out_illegal}, 32'd0);
    step();
    apply_stimulus(r_type(7'b0000000, 5'd2, 5'd1, 3'b011, 5'd4), 32'd1, 32'd2);
    step();
    check_output("sltu_data", out_data, 32'd1);
    step();
`else
    step();
    check_output("slt_ill",  {31'd0, out_illegal}, 32'd1);
    check_output("slt_data", out_data,             32'h0);
    step();
`endif

    // Reset while a result sits in WB: it must never be delivered
    out_ready = 1'b0;
    apply_stimulus(r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd5), 32'd10, 32'd20);
    step();
    check_output("rstwb_pre_valid", {31'd0, out_valid}, 32'd1);
    check_output("rstwb_pre_data",  out_data,           32'd30);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check_output("rstwb_valid", {31'd0, out_valid},   32'd0);
    check_output("rstwb_data",  out_data,             32'h0);
    check_output("rstwb_rd",    {27'd0, out_rd},      32'd0);
    check_output("rstwb_ill",   {31'd0, out_illegal}, 32'd0);
    check_output("rstwb_a",     alu_a,                32'h0);
    check_output("rstwb_b",     alu_b,                32'h0);
    check_output("rstwb_s",     {28'd0, alu_s},       32'h0);
    check_output("rstwb_ready", {31'd0, in_ready},    32'd1);
    out_ready = 1'b1;
    step();
    step();
    check_output("rstwb_no_beat", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential front end for the 32-bit combinational ALU.
- Accepts one RV32I OP / OP-IMM instruction per handshake, decodes it to the ALU 4-bit select code and selects operands (rs1, rs2/imm).
- Drives the ALU, captures its result, and presents a writeback packet on a valid/ready output.
- Sits between decode/regfile-read and the writeback mux of the single-cycle datapath.

Parameters:
XLEN, 32, datapath width; only 32 supported.
ILLEGAL_WB, 0, 1 = illegal instructions still produce an output beat (out_illegal=1); 0 = silently dropped.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  block can accept
in_instr  in  32  instruction word
in_rs1_data  in  32  rs1 value
in_rs2_data  in  32  rs2 value
alu_a  out  32  ALU operand a
alu_b  out  32  ALU operand b
alu_s  out  4  ALU select
alu_e  in  32  ALU result
alu_cout  in  1  ALU carry/borrow (bit 32 of add/sub)
out_valid  out  1  writeback valid
out_ready  in  1  writeback accepted
out_rd  out  5  destination register
out_data  out  32  result
out_illegal  out  1  instruction not supported

Behaviour:
- Reset: synchronous on rising clk with rst_n=0 → state IDLE; in_ready=0 during reset; out_valid, out_data, out_rd, out_illegal, alu_a, alu_b, alu_s all 0. Reset mid-transaction discards it; no output beat.
- FSM IDLE → ISSUE → WB → IDLE.
  - IDLE: in_ready=1. When in_valid=1, latch decoded alu_s, alu_a, alu_b, rd and illegal in registers, then go to ISSUE.
  - ISSUE: in_ready=0. Registered operands stay stable on alu_a/b/s. At the cycle end, capture alu_e into out_data, then go to WB.
  - WB: out_valid=1. out_rd, out_data and out_illegal stay stable until out_ready=1, then go to IDLE.
- Latency: accept → out_valid is 2 cycles. Max throughput is 1 instruction per 3 cycles. in_ready is never high while out_valid=1.
- Decode: alu_s = {f7b, funct3}.
  - Opcode 0110011 (R): operand b = rs2. f7b = instr[30]. funct7 must be 0000000, or 0100000 only with funct3 000/101.
  - Opcode 0010011 (I): operand b = sign-extended instr[31:20]. f7b=0, except funct3=101, where f7b = instr[30].
  - SLLI/SRLI/SRAI: imm[11:5] must be 0000000, or 0100000 only for SRAI; b = zero-extended instr[24:20].
  - Resulting codes: ADD 0000, SUB 1000, AND 0111, OR 0110, XOR 0100, SLL 0001, SRL 0101, SRA 1101.
  - Legal-decode rules (opcode, funct7/imm[11:5], funct3) are as stated above; funct3 010/011 is legal only with ALU_ISSUE_SLT_EN.
- Illegal instruction: any opcode other than the two above, or any violation of the legal-decode rules.
  - Issued as alu_s=0000, a=b=0.
  - out_data=0, out_rd=0, out_illegal=1.
  - If ILLEGAL_WB=0, WB is skipped (ISSUE → IDLE) and out_valid never rises.
- rd=0: out_rd=0 and out_data forced to 0 regardless of the ALU result.
- Operands are captured at accept; later changes to in_rs*_data or in_instr have no effect.

Optional Feature:
Macro ALU_ISSUE_SLT_EN.
- Defined: funct3 010 (SLT/SLTI) and 011 (SLTU/SLTIU) are legal.
  - Issue alu_s=1000 (SUB).
  - SLTU result = {31'b0, alu_cout}.
  - SLT result = (a[31]^b[31]) ? a[31] : alu_e[31], zero-extended.
- Undefined: funct3 010/011 is illegal.

Test Plan:
- ADD x5,x1,x2 with rs1=0xFFFFFFFF, rs2=1, out_ready=1 → alu_s=0000 in ISSUE; out_valid 2 cycles after accept; out_rd=5, out_data=0x00000000.
- SRAI x3,x4,4 with rs1=0x80000000 → alu_s=1101, alu_b=4, out_data=0xF8000000. SUB x3,x4,x6 with rs1=5, rs2=7 → alu_s=1000, out_data=0xFFFFFFFE.
- ADDI x7,x0,-1 with out_ready held 0 for 5 cycles → out_valid, out_data=0xFFFFFFFF and out_rd=7 stable the whole time; in_ready=0 throughout; returns to IDLE one cycle after out_ready=1.
- Opcode 0000011 (load), ILLEGAL_WB=1 → out_illegal=1, out_data=0, out_rd=0. Same instruction with ILLEGAL_WB=0 → no out_valid; in_ready high again 2 cycles after accept.
- rst_n=0 for one cycle while in WB → next cycle out_valid=0, all outputs 0, in_ready=1 (rst_n released); prior result never delivered.
- With ALU_ISSUE_SLT_EN: SLTU rs1=1, rs2=2 → out_data=1; SLT rs1=0xFFFFFFFF, rs2=1 → out_data=1. Without the macro, same SLT → out_illegal=1.
